// File: rtl/change_dispenser.sv
// change_dispenser: pays a change amount out one coin at a time (50/10/5/1),
// greedy by value with per-denomination inventory and shortfall reporting.
module change_dispenser #(
    parameter logic [7:0] INIT_CNT_50 = 8'd20,
    parameter logic [7:0] INIT_CNT_10 = 8'd20,
    parameter logic [7:0] INIT_CNT_5  = 8'd20,
    parameter logic [7:0] INIT_CNT_1  = 8'd20
) (
    input  logic       clk,
    input  logic       reset,
    input  logic [7:0] exchange,
    input  logic       coin_ready,
    input  logic       restock_en,
    input  logic [1:0] restock_sel,
    input  logic [7:0] restock_cnt,
    output logic       coin_valid,
    output logic [7:0] coin_out,
    output logic       busy,
    output logic       done,
    output logic [8:0] remaining,
    output logic [8:0] shortfall,
    output logic [7:0] cnt_50,
    output logic [7:0] cnt_10,
    output logic [7:0] cnt_5,
    output logic [7:0] cnt_1
);

    typedef enum logic [1:0] {
        IDLE,
        SELECT,
        DISPENSE,
        DONE
    } state_t;

    state_t          state_q, state_d;
    logic [8:0]      rem_q, rem_d;
    logic [8:0]      short_q, short_d;
    logic            valid_q, valid_d;
    logic [7:0]      coin_q, coin_d;
    logic [1:0]      idx_q, idx_d;
    logic [3:0][7:0] cnt_q, cnt_d;

    logic       pick_ok;
    logic [1:0] pick_idx;
    logic [7:0] pick_val;
    logic [8:0] ex9;
    logic [8:0] rs_sum;

    assign ex9    = {1'b0, exchange};
    assign rs_sum = {1'b0, cnt_q[restock_sel]} + {1'b0, restock_cnt};

    // Index 0..3 = 50/10/5/1, same order as restock_sel.
    always_comb begin
        pick_ok  = 1'b1;
        pick_idx = 2'd0;
        pick_val = 8'd0;
        if (rem_q >= 9'd50 && cnt_q[0] != 8'd0) begin
            pick_idx = 2'd0;
            pick_val = 8'd50;
        end else if (rem_q >= 9'd10 && cnt_q[1] != 8'd0) begin
            pick_idx = 2'd1;
            pick_val = 8'd10;
        end else if (rem_q >= 9'd5 && cnt_q[2] != 8'd0) begin
            pick_idx = 2'd2;
            pick_val = 8'd5;
        end else if (rem_q >= 9'd1 && cnt_q[3] != 8'd0) begin
            pick_idx = 2'd3;
            pick_val = 8'd1;
        end else begin
            pick_ok = 1'b0;
        end
    end

    always_comb begin
        state_d = state_q;
        rem_d   = rem_q + ex9;
        short_d = short_q;
        valid_d = valid_q;
        coin_d  = coin_q;
        idx_d   = idx_q;
        cnt_d   = cnt_q;
        case (state_q)
            IDLE: begin
                // A request that landed during DONE is already in rem_q.
                if (rem_d != 9'd0) state_d = SELECT;
                if (exchange == 8'd0 && restock_en)
                    cnt_d[restock_sel] = rs_sum[8] ? 8'hFF : rs_sum[7:0];
            end
            SELECT: begin
                if (rem_q == 9'd0) begin
                    short_d = 9'd0;
                    state_d = DONE;
                end else if (pick_ok) begin
                    valid_d = 1'b1;
                    coin_d  = pick_val;
                    idx_d   = pick_idx;
                    state_d = DISPENSE;
                end else begin
                    short_d = rem_q;
                    rem_d   = ex9;
                    state_d = DONE;
                end
            end
            DISPENSE: begin
                if (coin_ready) begin
                    rem_d        = rem_q - {1'b0, coin_q} + ex9;
                    cnt_d[idx_q] = cnt_q[idx_q] - 8'd1;
                    valid_d      = 1'b0;
                    coin_d       = 8'd0;
                    state_d      = SELECT;
                end
            end
            DONE: state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q  <= IDLE;
            rem_q    <= 9'd0;
            short_q  <= 9'd0;
            valid_q  <= 1'b0;
            coin_q   <= 8'd0;
            idx_q    <= 2'd0;
            cnt_q[0] <= INIT_CNT_50;
            cnt_q[1] <= INIT_CNT_10;
            cnt_q[2] <= INIT_CNT_5;
            cnt_q[3] <= INIT_CNT_1;
        end else begin
            state_q <= state_d;
            rem_q   <= rem_d;
            short_q <= short_d;
            valid_q <= valid_d;
            coin_q  <= coin_d;
            idx_q   <= idx_d;
            cnt_q   <= cnt_d;
        end
    end

    assign coin_valid = valid_q;
    assign coin_out   = coin_q;
    assign busy       = (state_q != IDLE);
    assign done       = (state_q == DONE);
    assign remaining  = rem_q;
    assign shortfall  = short_q;
    assign cnt_50     = cnt_q[0];
    assign cnt_10     = cnt_q[1];
    assign cnt_5      = cnt_q[2];
    assign cnt_1      = cnt_q[3];

endmodule

// File: tb/tb_change_dispenser.sv
// tb_change_dispenser: randomized and directed payouts checked against a
// transaction-level greedy change model with inventory tracking.
module tb_change_dispenser;

    logic       clk = 1'b0;
    logic       reset = 1'b1;
    logic [7:0] exchange = 8'd0;
    logic       coin_ready = 1'b0;
    logic       restock_en = 1'b0;
    logic [1:0] restock_sel = 2'd0;
    logic [7:0] restock_cnt = 8'd0;
    logic       coin_valid, busy, done;
    logic [7:0] coin_out, cnt_50, cnt_10, cnt_5, cnt_1;
    logic [8:0] remaining, shortfall;

    change_dispenser dut (
        .clk(clk), .reset(reset), .exchange(exchange),
        .coin_ready(coin_ready), .restock_en(restock_en),
        .restock_sel(restock_sel), .restock_cnt(restock_cnt),
        .coin_valid(coin_valid), .coin_out(coin_out), .busy(busy),
        .done(done), .remaining(remaining), .shortfall(shortfall),
        .cnt_50(cnt_50), .cnt_10(cnt_10), .cnt_5(cnt_5), .cnt_1(cnt_1)
    );

    always #5 clk = ~clk;

    int tests = 0;
    int fails = 0;
    int den[4] = '{50, 10, 5, 1};
    int m_inv[4];
    int exp_q[$];
    int exp_short;
    int acc[$];
    int done_cnt;
    int unstable;
    int vcyc_total;

    // Greedy payout model; extra is added to the owed amount after coin one.
    task automatic model_pay(input int amt, input int extra);
        int owed;
        int k;
        owed = amt;
        exp_q = {};
        exp_short = 0;
        forever begin
            if (owed == 0) break;
            k = -1;
            for (int i = 0; i < 4; i++)
                if (k < 0 && den[i] <= owed && m_inv[i] > 0) k = i;
            if (k < 0) begin
                exp_short = owed;
                break;
            end
            exp_q.push_back(den[k]);
            m_inv[k]--;
            owed -= den[k];
            if (exp_q.size() == 1) owed += extra;
        end
    endtask

    task automatic model_restock(input int sel, input int cnt);
        m_inv[sel] = (m_inv[sel] + cnt > 255) ? 255 : m_inv[sel] + cnt;
    endtask

    function automatic bit coins_eq();
        if (acc.size() != exp_q.size()) return 1'b0;
        foreach (acc[i]) if (acc[i] != exp_q[i]) return 1'b0;
        return 1'b1;
    endfunction

    task automatic do_reset();
        @(negedge clk);
        reset = 1'b1;
        exchange = 8'd0;
        coin_ready = 1'b0;
        restock_en = 1'b0;
        @(negedge clk);
        reset = 1'b0;
        m_inv = '{20, 20, 20, 20};
    endtask

    task automatic do_restock(input int sel, input int cnt);
        @(negedge clk);
        restock_en = 1'b1;
        restock_sel = sel[1:0];
        restock_cnt = cnt[7:0];
        @(negedge clk);
        restock_en = 1'b0;
    endtask

    // Drives one payout; returns at the negedge where done is seen.
    // mode 1: hold coin_ready low for 3 presented cycles per coin.
    task automatic run_payout(input int amt, input int extra, input int mode,
                              input int pct, input bit noise);
        bit got_done;
        bit sent_extra;
        int vc;
        logic [7:0] held;
        acc = {};
        done_cnt = 0;
        unstable = 0;
        vcyc_total = 0;
        got_done = 1'b0;
        sent_extra = 1'b0;
        vc = 0;
        held = 8'd0;
        @(negedge clk);
        exchange = amt[7:0];
        coin_ready = 1'b0;
        for (int c = 0; c < 4000 && !got_done; c++) begin
            @(negedge clk);
            exchange = 8'd0;
            if (done) begin
                done_cnt++;
                got_done = 1'b1;
                coin_ready = 1'b0;
                restock_en = 1'b0;
            end else begin
                restock_en = noise & ($urandom_range(0, 1) == 1);
                restock_sel = 2'($urandom_range(0, 3));
                restock_cnt = 8'($urandom_range(1, 255));
                if (coin_valid) begin
                    vcyc_total++;
                    if (vc == 0) held = coin_out;
                    else if (coin_out !== held) unstable++;
                end
                if (mode == 1) coin_ready = coin_valid && (vc >= 3);
                else coin_ready = ($urandom_range(0, 99) >= pct);
                if (coin_valid) vc++;
                if (coin_valid && coin_ready) begin
                    if (acc.size() == 0 && extra != 0 && !sent_extra) begin
                        exchange = extra[7:0];
                        sent_extra = 1'b1;
                    end
                    acc.push_back(int'(coin_out));
                    vc = 0;
                end
            end
        end
        if (!got_done) begin
            tests++;
            fails++;
            $display("FAIL timeout: no done pulse for amount %0d", amt);
        end
    endtask

    task automatic test_reset();
        do_reset();
        tests++;
        if (coin_valid !== 1'b0 || coin_out !== 8'd0 || busy !== 1'b0 ||
            done !== 1'b0 || remaining !== 9'd0 || shortfall !== 9'd0) begin
            fails++;
            $display("FAIL reset_outs: v=%b c=%0d b=%b d=%b r=%0d s=%0d want 0s",
                     coin_valid, coin_out, busy, done, remaining, shortfall);
        end
        tests++;
        if (cnt_50 !== 8'd20 || cnt_10 !== 8'd20 || cnt_5 !== 8'd20 ||
            cnt_1 !== 8'd20) begin
            fails++;
            $display("FAIL reset_cnts: %0d %0d %0d %0d want 20 each",
                     cnt_50, cnt_10, cnt_5, cnt_1);
        end
    endtask

    task automatic test_basic();
        do_reset();
        model_pay(35, 0);
        run_payout(35, 0, 0, 0, 1'b0);
        tests++;
        if (!coins_eq() || acc.size() != 4) begin
            fails++;
            $display("FAIL basic_coins: got %p want %p", acc, exp_q);
        end
        tests++;
        if (remaining !== 9'd0 || shortfall !== 9'd0 || done_cnt != 1) begin
            fails++;
            $display("FAIL basic_done: rem=%0d short=%0d dones=%0d want 0 0 1",
                     remaining, shortfall, done_cnt);
        end
        tests++;
        if (cnt_10 !== 8'd17 || cnt_5 !== 8'd19 || cnt_50 !== 8'd20) begin
            fails++;
            $display("FAIL basic_cnts: c10=%0d c5=%0d c50=%0d want 17 19 20",
                     cnt_10, cnt_5, cnt_50);
        end
        @(negedge clk);
        tests++;
        if (done !== 1'b0 || busy !== 1'b0) begin
            fails++;
            $display("FAIL basic_pulse: done=%b busy=%b want 0 0", done, busy);
        end
    endtask

    task automatic test_stall();
        do_reset();
        model_pay(66, 0);
        run_payout(66, 0, 1, 0, 1'b1);
        tests++;
        if (!coins_eq()) begin
            fails++;
            $display("FAIL stall_coins: got %p want %p", acc, exp_q);
        end
        tests++;
        if (unstable != 0 || vcyc_total != 16) begin
            fails++;
            $display("FAIL stall_hold: unstable=%0d valid_cycles=%0d want 0 16",
                     unstable, vcyc_total);
        end
        tests++;
        if (cnt_50 !== 8'(m_inv[0]) || cnt_10 !== 8'(m_inv[1]) ||
            cnt_5 !== 8'(m_inv[2]) || cnt_1 !== 8'(m_inv[3])) begin
            fails++;
            $display("FAIL stall_cnts: %0d %0d %0d %0d want %p",
                     cnt_50, cnt_10, cnt_5, cnt_1, m_inv);
        end
    endtask

    task automatic test_depleted_10();
        int bad;
        bad = 0;
        do_reset();
        for (int i = 0; i < 5; i++) begin
            model_pay(i < 4 ? 40 : 30, 0);
            run_payout(i < 4 ? 40 : 30, 0, 0, 30, 1'b0);
            if (!coins_eq()) bad++;
        end
        model_pay(30, 0);
        run_payout(30, 0, 0, 30, 1'b0);
        tests++;
        if (bad != 0 || !coins_eq() || cnt_10 !== 8'd0) begin
            fails++;
            $display("FAIL dep10: got %p want %p drain_bad=%0d c10=%0d want 0",
                     acc, exp_q, bad, cnt_10);
        end
    endtask

    task automatic test_shortfall();
        int bad;
        bad = 0;
        do_reset();
        for (int i = 0; i < 25; i++) begin
            model_pay(i < 4 ? 4 : (i == 4 ? 2 : 5), 0);
            run_payout(i < 4 ? 4 : (i == 4 ? 2 : 5), 0, 0, 0, 1'b0);
            if (!coins_eq()) bad++;
        end
        model_pay(4, 0);
        run_payout(4, 0, 0, 0, 1'b0);
        tests++;
        if (bad != 0 || !coins_eq()) begin
            fails++;
            $display("FAIL short_coins: got %p want %p drain_bad=%0d",
                     acc, exp_q, bad);
        end
        tests++;
        if (shortfall !== 9'd2 || cnt_1 !== 8'd0 || cnt_5 !== 8'd0 ||
            remaining !== 9'd0) begin
            fails++;
            $display("FAIL short_val: short=%0d c1=%0d c5=%0d rem=%0d want 2 0 0 0",
                     shortfall, cnt_1, cnt_5, remaining);
        end
        model_pay(10, 0);
        run_payout(10, 0, 0, 0, 1'b0);
        tests++;
        if (shortfall !== 9'd0 || !coins_eq()) begin
            fails++;
            $display("FAIL short_clear: short=%0d got %p want 0 %p",
                     shortfall, acc, exp_q);
        end
    endtask

    task automatic test_back_to_back();
        int sum;
        do_reset();
        model_pay(35, 20);
        run_payout(35, 20, 0, 40, 1'b1);
        sum = 0;
        foreach (acc[i]) sum += acc[i];
        tests++;
        if (!coins_eq() || sum != 55) begin
            fails++;
            $display("FAIL b2b_coins: got %p sum=%0d want %p sum=55",
                     acc, sum, exp_q);
        end
        tests++;
        if (done_cnt != 1 || remaining !== 9'd0 || shortfall !== 9'd0) begin
            fails++;
            $display("FAIL b2b_done: dones=%0d rem=%0d short=%0d want 1 0 0",
                     done_cnt, remaining, shortfall);
        end
        @(negedge clk);
        tests++;
        if (busy !== 1'b0 || done !== 1'b0) begin
            fails++;
            $display("FAIL b2b_idle: busy=%b done=%b want 0 0", busy, done);
        end
    endtask

    task automatic test_reset_mid();
        do_reset();
        model_pay(35, 0);
        run_payout(35, 0, 0, 0, 1'b0);
        @(negedge clk);
        exchange = 8'd25;
        coin_ready = 1'b0;
        repeat (3) begin
            @(negedge clk);
            exchange = 8'd0;
        end
        tests++;
        if (remaining !== 9'd25 || coin_valid !== 1'b1 || coin_out !== 8'd10) begin
            fails++;
            $display("FAIL mid_state: rem=%0d v=%b coin=%0d want 25 1 10",
                     remaining, coin_valid, coin_out);
        end
        do_reset();
        tests++;
        if (coin_valid !== 1'b0 || coin_out !== 8'd0 || busy !== 1'b0 ||
            done !== 1'b0 || remaining !== 9'd0 || shortfall !== 9'd0 ||
            cnt_10 !== 8'd20 || cnt_5 !== 8'd20) begin
            fails++;
            $display("FAIL mid_reset: v=%b c=%0d b=%b r=%0d c10=%0d c5=%0d",
                     coin_valid, coin_out, busy, remaining, cnt_10, cnt_5);
        end
        do_restock(0, 250);
        do_restock(2, 7);
        tests++;
        if (cnt_50 !== 8'd255 || cnt_5 !== 8'd27) begin
            fails++;
            $display("FAIL restock_sat: c50=%0d c5=%0d want 255 27",
                     cnt_50, cnt_5);
        end
    endtask

    task automatic test_random();
        int amt, sel, cnt, bad;
        bad = 0;
        do_reset();
        for (int it = 0; it < 30; it++) begin
            if ($urandom_range(0, 2) == 0) begin
                sel = $urandom_range(0, 3);
                cnt = ($urandom_range(0, 4) == 0) ? $urandom_range(0, 255)
                                                  : $urandom_range(0, 15);
                model_restock(sel, cnt);
                do_restock(sel, cnt);
            end
            amt = $urandom_range(1, 255);
            model_pay(amt, 0);
            run_payout(amt, 0, 0, $urandom_range(0, 70), 1'b1);
            tests++;
            if (!coins_eq() || shortfall !== 9'(exp_short) ||
                remaining !== 9'd0 || done_cnt != 1) begin
                fails++;
                bad++;
                $display("FAIL rand_pay amt=%0d: got %p short=%0d want %p short=%0d",
                         amt, acc, shortfall, exp_q, exp_short);
            end
            tests++;
            if (cnt_50 !== 8'(m_inv[0]) || cnt_10 !== 8'(m_inv[1]) ||
                cnt_5 !== 8'(m_inv[2]) || cnt_1 !== 8'(m_inv[3])) begin
                fails++;
                $display("FAIL rand_cnts: %0d %0d %0d %0d want %p",
                         cnt_50, cnt_10, cnt_5, cnt_1, m_inv);
            end
            if (bad > 3) break;
        end
    endtask

    initial begin
        test_reset();
        test_basic();
        test_stall();
        test_depleted_10();
        test_shortfall();
        test_back_to_back();
        test_reset_mid();
        test_random();
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
